dotp_scheduler: RTL and testbench

Command-driven sequencer for the dot-product datapath. It accepts a job (base address, vector count) over a valid/ready handshake and drives a shared read enable and address into the two operand memories. It multiply-accumulates the returned element pairs and emits one dot-product result per VECTOR_WIDTH-element vector over a valid/ready output channel. It sits between the command source (testbench or host FSM) and the mem1/mem2 read ports, and replaces free-running sweep reading with job-scoped, back-pressurable reads.

---
 rtl/dotp_pkg.sv | 17 +
 rtl/dotp_mac.sv | 50 +++++
 rtl/dotp_scheduler.sv | 139 +++++++++++++
 tb/tb_dotp_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dotp_pkg.sv
// Shared types and sizing for the dot-product scheduler: FSM state enum and accumulator width.
package dotp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAST,
    OUT,
    DONE
  } dotp_state_t;

  // Headroom of log2(vec_w) bits lets a full vector of max products sum without overflow.
  function automatic int acc_width(input int data_w, input int vec_w);
    return 2 * data_w + $clog2(vec_w);
  endfunction

endpackage

// File: rtl/dotp_mac.sv
// Registered multiply-accumulate; result visible the cycle after i_en, i_clr wins over i_en.
// Signed operands when DOTP_SIGNED_EN is defined, unsigned otherwise; no backpressure (caller gates i_en).
module dotp_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [ACC_WIDTH-1:0]  o_acc
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [PW-1:0]        w_a;
  logic [PW-1:0]        w_b;
  logic [PW-1:0]        w_prod;
  logic [ACC_WIDTH-1:0] w_prod_ext;
  logic [ACC_WIDTH-1:0] r_acc;

  // Operands are widened to the product width first, so the low PW bits of the
  // multiply are exact for both two's-complement and unsigned interpretation.
`ifdef DOTP_SIGNED_EN
  assign w_a        = {{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a};
  assign w_b        = {{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b};
  assign w_prod     = w_a * w_b;
  assign w_prod_ext = {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};
`else
  assign w_a        = {{DATA_WIDTH{1'b0}}, i_a};
  assign w_b        = {{DATA_WIDTH{1'b0}}, i_b};
  assign w_prod     = w_a * w_b;
  assign w_prod_ext = {{(ACC_WIDTH-PW){1'b0}}, w_prod};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/dotp_scheduler.sv
// Job sequencer: reads VECTOR_WIDTH element pairs per vector, result VECTOR_WIDTH+2 cycles after accept.
// Reads stall entirely while a result waits for res_ready; signed operands with DOTP_SIGNED_EN.
module dotp_scheduler
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int ADDR_WIDTH   = 5,
  parameter int ACC_WIDTH    = acc_width(DATA_WIDTH, VECTOR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_num_vec,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] mem1_data,
  input  logic [DATA_WIDTH-1:0] mem2_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  res_last,
  output logic                  busy,
  output logic                  done
);

  localparam int            EW        = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam logic [EW-1:0] ELEM_LAST = EW'(VECTOR_WIDTH - 1);

  dotp_state_t           r_state;
  dotp_state_t           w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_num_vec;
  logic [ADDR_WIDTH-1:0] r_vec_cnt;
  logic [EW-1:0]         r_elem_cnt;
  logic                  r_rd_en_d;
  logic                  w_accept;
  logic                  w_last_vec;
  logic                  w_elem_last;
  logic                  w_acc_clr;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ACC_WIDTH-1:0]  w_acc;

  assign w_accept    = (r_state == IDLE) && cmd_valid;
  assign w_last_vec  = (r_vec_cnt == (r_num_vec - ADDR_WIDTH'(1)));
  assign w_elem_last = (r_elem_cnt == ELEM_LAST);
  // Truncation to ADDR_WIDTH gives the intended modulo wrap of the address space.
  assign w_addr      = r_base + ADDR_WIDTH'(r_vec_cnt * VECTOR_WIDTH) + ADDR_WIDTH'(r_elem_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    rd_en     = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    w_acc_clr = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_acc_clr = 1'b1;
          w_next    = (cmd_num_vec == '0) ? DONE : READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (w_elem_last) w_next = LAST;
      end
      LAST: w_next = OUT;
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_next    = w_last_vec ? DONE : READ;
          w_acc_clr = !w_last_vec;
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_num_vec  <= '0;
      r_vec_cnt  <= '0;
      r_elem_cnt <= '0;
      r_rd_en_d  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_base     <= cmd_base_addr;
        r_num_vec  <= cmd_num_vec;
        r_vec_cnt  <= '0;
        r_elem_cnt <= '0;
      end
      // elem_cnt returns to zero on leaving READ, ready for the next vector.
      if (r_state == READ) begin
        r_elem_cnt <= w_elem_last ? '0 : r_elem_cnt + EW'(1);
      end
      if ((r_state == OUT) && res_ready && !w_last_vec) begin
        r_vec_cnt <= r_vec_cnt + ADDR_WIDTH'(1);
      end
      r_rd_en_d <= rd_en;
    end
  end

  dotp_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .i_clr(w_acc_clr),
    .i_en (r_rd_en_d),
    .i_a  (mem1_data),
    .i_b  (mem2_data),
    .o_acc(w_acc)
  );

  assign rd_addr  = rd_en ? w_addr : '0;
  assign res_data = w_acc;
  assign res_last = res_valid && w_last_vec;

endmodule

// File: tb/tb_dotp_scheduler.sv
// Directed bench for dotp_scheduler with a registered two-port memory model.
module tb_dotp_scheduler;

  localparam int DW   = 8;
  localparam int VW   = 4;
  localparam int AW   = 5;
  localparam int ACCW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr;
  logic [AW-1:0] cmd_num_vec;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] mem1_data = '0;
  logic [DW-1:0] mem2_data = '0;
  logic          res_valid;
  logic          res_ready;
  logic [ACCW-1:0] res_data;
  logic          res_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem1 [32];
  logic [DW-1:0] mem2 [32];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      mem1_data <= mem1[rd_addr];
      mem2_data <= mem2[rd_addr];
    end
  end

  dotp_scheduler #(
    .DATA_WIDTH  (DW),
    .VECTOR_WIDTH(VW),
    .ADDR_WIDTH  (AW),
    .ACC_WIDTH   (ACCW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base_addr(cmd_base_addr),
    .cmd_num_vec  (cmd_num_vec),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .mem1_data    (mem1_data),
    .mem2_data    (mem2_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_last     (res_last),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the cycle after the accept edge.
  task automatic start(input logic [AW-1:0] b, input logic [AW-1:0] n);
    cmd_base_addr = b;
    cmd_num_vec   = n;
    cmd_valid     = 1'b1;
    tick();
    cmd_valid     = 1'b0;
    cmd_base_addr = ~b;
    cmd_num_vec   = ~n;
  endtask

  task automatic run_single(input string tag, input logic [AW-1:0] b, input logic [31:0] expv);
    start(b, 1);
    repeat (4) tick();
    check({tag, "_no_res_early"}, res_valid, 0);
    tick();
    check({tag, "_res_valid"}, res_valid, 1);
    check({tag, "_res_data"}, res_data, expv);
    check({tag, "_res_last"}, res_last, 1);
    tick();
    check({tag, "_done"}, done, 1);
    tick();
  endtask

  initial begin
    logic [AW-1:0] a;
    cmd_valid = 0; cmd_base_addr = '0; cmd_num_vec = '0; res_ready = 0;
    for (int i = 0; i < 32; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_last", res_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #10 rst_n = 1'b1;
    tick();

    // Single vector: 1*5+2*6+3*7+4*8 = 70
    for (int i = 0; i < 4; i++) begin
      mem1[i] = DW'(i + 1);
      mem2[i] = DW'(i + 5);
    end
    res_ready = 1;
    start(0, 1);
    check("t1_busy", busy, 1);
    check("t1_cmd_ready", cmd_ready, 0);
    for (int k = 0; k < 4; k++) begin
      check("t1_rd_en", rd_en, 1);
      check("t1_rd_addr", rd_addr, k);
      tick();
    end
    check("t1_rd_en_off", rd_en, 0);
    check("t1_res_early", res_valid, 0);
    tick();
    check("t1_res_valid", res_valid, 1);
    check("t1_res_data", res_data, 70);
    check("t1_res_last", res_last, 1);
    tick();
    check("t1_done", done, 1);
    check("t1_res_valid_off", res_valid, 0);
    tick();
    check("t1_done_off", done, 0);
    check("t1_cmd_ready_back", cmd_ready, 1);
    check("t1_busy_off", busy, 0);

    // Two vectors, 3-cycle stall on the first result; second = 2*(1+2+3+4) = 20
    for (int i = 4; i < 8; i++) begin
      mem1[i] = 8'd2;
      mem2[i] = DW'(i - 3);
    end
    res_ready = 0;
    start(0, 2);
    repeat (5) tick();
    check("t2_res_valid", res_valid, 1);
    check("t2_res_data0", res_data, 70);
    check("t2_res_last0", res_last, 0);
    cmd_valid   = 1'b1;
    cmd_num_vec = 5'd9;
    for (int s = 0; s < 3; s++) begin
      check("t2_stall_data", res_data, 70);
      check("t2_stall_valid", res_valid, 1);
      check("t2_stall_rd_en", rd_en, 0);
      check("t2_stall_last", res_last, 0);
      tick();
    end
    cmd_valid = 1'b0;
    res_ready = 1;
    check("t2_hs_data", res_data, 70);
    tick();
    check("t2_v1_rd_en", rd_en, 1);
    check("t2_v1_rd_addr", rd_addr, 4);
    check("t2_v1_res_off", res_valid, 0);
    repeat (5) tick();
    check("t2_res_valid1", res_valid, 1);
    check("t2_res_data1", res_data, 20);
    check("t2_res_last1", res_last, 1);
    tick();
    check("t2_done", done, 1);
    tick();

    // Address wrap: 3*10 + 4*10 + 1*5 + 2*6 = 87
    mem1[30] = 8'd3; mem1[31] = 8'd4;
    mem2[30] = 8'd10; mem2[31] = 8'd10;
    start(5'd30, 1);
    for (int k = 0; k < 4; k++) begin
      a = AW'(30 + k);
      check("t3_rd_addr", rd_addr, a);
      tick();
    end
    tick();
    check("t3_res_data", res_data, 87);
    check("t3_res_last", res_last, 1);
    tick();
    check("t3_done", done, 1);
    tick();

    // Max operands; 0x80 gives 65536 under both signedness choices
    for (int i = 8; i < 12; i++) begin
      mem1[i] = 8'hFF; mem2[i] = 8'hFF;
    end
    for (int i = 12; i < 16; i++) begin
      mem1[i] = 8'h80; mem2[i] = 8'h80;
    end
`ifdef DOTP_SIGNED_EN
    run_single("t4_ff", 5'd8, 4);
`else
    run_single("t4_ff", 5'd8, 260100);
`endif
    run_single("t4_80", 5'd12, 65536);

    // Zero-length job
    start(5'd5, 0);
    check("t5_done", done, 1);
    check("t5_rd_en", rd_en, 0);
    check("t5_res_valid", res_valid, 0);
    check("t5_busy", busy, 1);
    tick();
    check("t5_done_off", done, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    check("t5_rd_en_after", rd_en, 0);

    // Reset mid-job, then a clean job
    start(0, 1);
    tick();
    check("t6_in_read", rd_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rd_en", rd_en, 0);
    check("t6_rd_addr", rd_addr, 0);
    check("t6_res_valid", res_valid, 0);
    check("t6_res_data", res_data, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    tick();
    check("t6_no_done_pulse", done, 0);
    rst_n = 1'b1;
    tick();
    run_single("t6_after", 5'd0, 70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
